// File: rtl/powlib_bus_pkg.sv
// Shared bus definitions for powlib responders: opcode encodings and the
// responder state encoding.
package powlib_bus_pkg;

  localparam int B_OW = 2;

  localparam logic [B_OW-1:0] OP_WRITE = 2'b00;
  localparam logic [B_OW-1:0] OP_READ  = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/powlib_busresp_ram.sv
// Single-write single-read word RAM with a registered read port. The array is
// never reset; only the read register clears so the response data starts at 0.
module powlib_busresp_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read data holds between reads so it can sit on the output bus under backpressure.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/powlib_busresp.sv
// Memory-mapped bus responder: stores write packets into a local RAM and answers
// read requests with a response packet sent to the return address in the request data.
module powlib_busresp
  import powlib_bus_pkg::*;
#(
  parameter              ID   = "BUSRESP",
  parameter int          EDBG = 0,
  parameter int          B_AW = 16,
  parameter int          B_DW = 32,
  parameter int          B_OW = 2,
  parameter logic [B_AW-1:0] BASE = 16'h0000,
  parameter logic [B_AW-1:0] SIZE = 16'h00FF,
  parameter int          EW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_DW-1:0] indata,
  input  logic [B_AW-1:0] inaddr,
  input  logic [B_OW-1:0] inop,
  input  logic            invld,
  output logic            inrdy,
  output logic [B_DW-1:0] outdata,
  output logic [B_AW-1:0] outaddr,
  output logic            outvld,
  input  logic            outrdy,
  output logic [EW-1:0]   errs,
  output state_t          dbgstate
);

  // Handshake: a packet moves on a rising clk edge where vld and rdy are both 1;
  // the producer holds vld and payload steady until then, and outvld/outdata/
  // outaddr hold while outvld is high and outrdy is low.

  localparam int RAW = $clog2(32'(SIZE) + 32'd1);

  state_t          state_q, state_d;
  logic            inrdy_q, inrdy_d;
  logic [B_AW-1:0] outaddr_q, outaddr_d;
  logic [EW-1:0]   errs_q, errs_d;

  logic [B_AW:0]   offset;
  logic            hit, accept, is_wr, is_rd;
  logic            ram_we, ram_re, drop;

  // One extra bit keeps addresses below BASE from wrapping into the window.
  assign offset = {1'b0, inaddr} - {1'b0, BASE};
  assign hit    = !offset[B_AW] && (offset[B_AW-1:0] <= SIZE);

  assign accept = invld && inrdy_q;
  assign is_wr  = (inop == OP_WRITE);
  assign is_rd  = (inop == OP_READ);
  assign ram_we = accept && is_wr && hit;
  assign ram_re = accept && is_rd && hit;
  assign drop   = accept && !(ram_we || ram_re);

  always_comb begin
    state_d   = state_q;
    outaddr_d = outaddr_q;
    errs_d    = errs_q;
    case (state_q)
      IDLE: if (ram_re) state_d = RESP;
      RESP: if (outrdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ram_re) outaddr_d = indata[B_AW-1:0];
    if (drop && (errs_q != {EW{1'b1}})) errs_d = errs_q + 1'b1;
    inrdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      inrdy_q   <= 1'b0;
      outaddr_q <= '0;
      errs_q    <= '0;
    end else begin
      state_q   <= state_d;
      inrdy_q   <= inrdy_d;
      outaddr_q <= outaddr_d;
      errs_q    <= errs_d;
    end
  end

  powlib_busresp_ram #(
    .DW (B_DW),
    .AW (RAW)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .waddr_i (offset[RAW-1:0]),
    .wdata_i (indata),
    .re_i    (ram_re),
    .raddr_i (offset[RAW-1:0]),
    .rdata_o (outdata)
  );

  assign inrdy    = inrdy_q;
  assign outvld   = (state_q == RESP);
  assign outaddr  = outaddr_q;
  assign errs     = errs_q;
  assign dbgstate = state_q;

  // ID and EDBG only name/enable simulation-side debug prints kept outside this file.
  logic unused_dbg;
  assign unused_dbg = ^{ID, EDBG};

endmodule

// File: tb/tb_powlib_busresp.sv
// Directed bench for powlib_busresp: drives write/read/reserved packets and
// scoreboards every response against a bench-side memory model.
module tb_powlib_busresp;
  import powlib_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] indata = '0;
  logic [15:0] inaddr = '0;
  logic [1:0]  inop = '0;
  logic        invld = 1'b0;
  logic        inrdy;
  logic [31:0] outdata;
  logic [15:0] outaddr;
  logic        outvld;
  logic        outrdy = 1'b1;
  logic [7:0]  errs;
  state_t      dbgstate;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int stalls = 0;
  int acc_cyc = 0;
  int resp_cnt = 0;
  int first_acc, last_acc;

  logic [47:0] exp_q[$];
  logic [31:0] model_mem [0:255];

  powlib_busresp dut (
    .clk      (clk),
    .rst      (rst),
    .indata   (indata),
    .inaddr   (inaddr),
    .inop     (inop),
    .invld    (invld),
    .inrdy    (inrdy),
    .outdata  (outdata),
    .outaddr  (outaddr),
    .outvld   (outvld),
    .outrdy   (outrdy),
    .errs     (errs),
    .dbgstate (dbgstate)
  );

  // Clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: each is entered #1 after a rising edge and returns #1 after the accept edge.
  task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data);
    int n;
    inop = op;
    inaddr = addr;
    indata = data;
    invld = 1'b1;
    n = 0;
    while (!inrdy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    stalls += n;
    if (n >= 50) begin
      check("send_timeout", 64'd0, 64'd1);
      invld = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      invld = 1'b0;
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    send(OP_WRITE, addr, data);
    model_mem[addr[7:0]] = data;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] ret);
    exp_q.push_back({ret, model_mem[addr[7:0]]});
    send(OP_READ, addr, {16'h0, ret});
  endtask

  // Scoreboard: a response transfers on the edge following a low phase with outvld&outrdy.
  always @(negedge clk) begin
    if (rst && outvld && outrdy) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {16'h0, outaddr, outdata}, 64'd0);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("resp_addr_data", {16'h0, outaddr, outdata}, {16'h0, e});
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_inrdy", inrdy, 1'b0);
    check("rst_outvld", outvld, 1'b0);
    check("rst_outdata", outdata, 32'h0);
    check("rst_outaddr", outaddr, 16'h0);
    check("rst_errs", errs, 8'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("inrdy_before_edge", inrdy, 1'b0);
    @(posedge clk);
    #1 check("inrdy_after_release", inrdy, 1'b1);

    // 1: write then read with 1-cycle latency
    wr(16'h0010, 32'hDEADBEEF);
    rd(16'h0010, 16'h4000);
    check("t1_outvld", outvld, 1'b1);
    check("t1_outaddr", outaddr, 16'h4000);
    check("t1_outdata", outdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // 2: response held under backpressure
    outrdy = 1'b0;
    rd(16'h0010, 16'h4000);
    for (int i = 0; i < 5; i++) begin
      check("t2_outvld", outvld, 1'b1);
      check("t2_outdata", outdata, 32'hDEADBEEF);
      check("t2_outaddr", outaddr, 16'h4000);
      check("t2_inrdy", inrdy, 1'b0);
      @(posedge clk);
      #1;
    end
    outrdy = 1'b1;
    @(posedge clk);
    #1;
    check("t2_state_idle", dbgstate, IDLE);
    check("t2_outvld_drop", outvld, 1'b0);

    // 3: out-of-range write and reserved opcode are dropped
    wr(16'h0000, 32'h12345678);
    send(OP_WRITE, 16'h0100, 32'hBAD0BAD0);
    send(2'b10, 16'h0000, 32'hFFFF0000);
    check("t3_errs", errs, 8'd2);
    repeat (2) begin
      check("t3_no_resp", outvld, 1'b0);
      @(posedge clk);
      #1;
    end
    rd(16'h0000, 16'h0123);
    @(posedge clk);
    #1;

    // 4: 256 back-to-back writes, then 256 reads at one per two cycles
    stalls = 0;
    for (int i = 0; i < 256; i++) wr(16'(i), 32'(i) ^ 32'hA5A5A5A5);
    check("t4_write_stalls", stalls, 0);
    for (int i = 0; i < 256; i++) begin
      rd(16'(i), 16'h8000 | 16'(i));
      if (i == 0) first_acc = acc_cyc;
      last_acc = acc_cyc;
    end
    check("t4_read_rate", last_acc - first_acc, 510);
    @(posedge clk);
    #1;
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_resp_count", resp_cnt, 259);

    // 5: reset while a response is pending
    outrdy = 1'b0;
    rd(16'h0005, 16'h0777);
    check("t5_outvld_pre", outvld, 1'b1);
    check("t5_errs_pre", errs, 8'd2);
    #2 rst = 1'b0;
    #1;
    check("t5_outvld_async", outvld, 1'b0);
    check("t5_errs_async", errs, 8'h0);
    check("t5_inrdy_async", inrdy, 1'b0);
    exp_q.delete();
    outrdy = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("t5_inrdy_held", inrdy, 1'b0);
    @(posedge clk);
    #1 check("t5_inrdy_release", inrdy, 1'b1);

    // 6: error counter saturation
    for (int i = 0; i < 254; i++) send(2'b11, 16'(i), 32'h0);
    check("t6_errs_254", errs, 8'hFE);
    for (int i = 0; i < 46; i++) send(2'b11, 16'(i), 32'h0);
    check("t6_errs_sat", errs, 8'hFF);
    check("t6_no_resp", resp_cnt, 259);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
